// File: rtl/tow_pkg.sv
// tow_pkg: shared state encoding and LED mux select constants for the tug-of-war game.
package tow_pkg;
    typedef enum logic [1:0] {S_RST, S_READY, S_PLAY, S_WIN} state_t;
    localparam logic [1:0] LEDS_ALL_OFF   = 2'd0;
    localparam logic [1:0] LEDS_ALL_ON    = 2'd1;
    localparam logic [1:0] LEDS_RESET_CODE = 2'd2;
    localparam logic [1:0] LEDS_SCORE     = 2'd3;
    localparam logic [6:0] SCORE_CENTER   = 7'b0001000;
endpackage

// File: rtl/tow_tick_timer.sv
// tow_tick_timer: loadable 4-bit tick down-counter; done pulses on the tick that takes it 1 -> 0.
module tow_tick_timer #(
    parameter int RST_VAL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] val,
    input  logic       tick,
    output logic       done
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? val : (tick && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 4'(RST_VAL);
        else     cnt_q <= cnt_d;
    end

    assign done = tick && cnt_q == 4'd1;
endmodule

// File: rtl/tow_game_ctrl.sv
// tow_game_ctrl: tug-of-war sequencer driving the LED mux select, the one-hot marker and win flags.
module tow_game_ctrl
    import tow_pkg::*;
#(
    parameter int RESET_TICKS = 4,
    parameter int READY_TICKS = 4,
    parameter int FLASH_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       pbl,
    input  logic       pbr,
    output logic [1:0] leds_ctrl,
    output logic [6:0] score,
    output logic       win_l,
    output logic       win_r
);
    state_t     state_q, state_d;
    logic [1:0] leds_q, leds_d;
    logic [6:0] score_q, score_d;
    logic       win_l_q, win_l_d, win_r_q, win_r_d;
    logic       load, done;
    logic [3:0] val;

    tow_tick_timer #(.RST_VAL(RESET_TICKS)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .val  (val),
        .tick (tick),
        .done (done)
    );

    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        score_d = score_q;
        win_l_d = win_l_q;
        win_r_d = win_r_q;
        load    = 1'b0;
        val     = 4'(FLASH_TICKS);
        case (state_q)
            S_RST: if (done) begin
                state_d = S_READY;
                leds_d  = LEDS_ALL_ON;
                load    = 1'b1;
                val     = 4'(READY_TICKS);
            end
            S_READY: if (done) begin
                state_d = S_PLAY;
                leds_d  = LEDS_SCORE;
                score_d = SCORE_CENTER;
            end
            S_PLAY: if (pbl ^ pbr) begin
                // a press on the end LED wins; the flash timer starts at the same time
                if ((pbl && score_q[6]) || (pbr && score_q[0])) begin
                    state_d = S_WIN;
                    win_l_d = pbl;
                    win_r_d = pbr;
                    load    = 1'b1;
                end else begin
                    score_d = pbl ? score_q << 1 : score_q >> 1;
                end
            end
            S_WIN: if (done) begin
                leds_d = leds_q == LEDS_SCORE ? LEDS_ALL_OFF : LEDS_SCORE;
                load   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RST;
            leds_q  <= LEDS_RESET_CODE;
            score_q <= SCORE_CENTER;
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            score_q <= score_d;
            win_l_q <= win_l_d;
            win_r_q <= win_r_d;
        end
    end

    assign leds_ctrl = leds_q;
    assign score     = score_q;
    assign win_l     = win_l_q;
    assign win_r     = win_r_q;
endmodule

// File: tb/tb_tow_game_ctrl.sv
// tb_tow_game_ctrl: directed and random stimulus against a position/phase model of the game.
module tb_tow_game_ctrl;
    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, pbl = 1'b0, pbr = 1'b0;
    logic [1:0] leds_ctrl;
    logic [6:0] score;
    logic       win_l, win_r;
    int         total = 0, bad = 0;
    // model: phase 0 reset code, 1 ready, 2 play, 3 won; pos is marker LED index (6 = left end)
    int         m_phase, m_left, m_pos, m_leds;
    logic       m_wl, m_wr;

    tow_game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .pbl       (pbl),
        .pbr       (pbr),
        .leds_ctrl (leds_ctrl),
        .score     (score),
        .win_l     (win_l),
        .win_r     (win_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic t, input logic l, input logic rr);
        if (r) begin
            m_phase = 0; m_left = 4; m_pos = 3; m_leds = 2; m_wl = 0; m_wr = 0;
        end else if (m_phase == 2) begin
            if (l && !rr) begin
                if (m_pos == 6) begin m_phase = 3; m_wl = 1; m_left = 2; end
                else m_pos++;
            end else if (rr && !l) begin
                if (m_pos == 0) begin m_phase = 3; m_wr = 1; m_left = 2; end
                else m_pos--;
            end
        end else if (t) begin
            m_left--;
            if (m_left == 0) begin
                if (m_phase == 0) begin m_phase = 1; m_leds = 1; m_left = 4; end
                else if (m_phase == 1) begin m_phase = 2; m_leds = 3; m_pos = 3; end
                else begin m_leds = (m_leds == 3) ? 0 : 3; m_left = 2; end
            end
        end
    endtask

    task automatic step(input logic t, input logic l, input logic r, input logic x = 1'b0);
        rst = x; tick = t; pbl = l; pbr = r;
        @(posedge clk);
        model(x, t, l, r);
        #1;
        rst = 1'b0; tick = 1'b0; pbl = 1'b0; pbr = 1'b0;
        check("leds_ctrl", 7'(leds_ctrl), 7'(m_leds));
        check("score", score, 7'(1 << m_pos));
        check("win_l", 7'(win_l), 7'(m_wl));
        check("win_r", 7'(win_r), 7'(m_wr));
    endtask

    task automatic to_play();
        for (int i = 0; i < 400 && m_phase != 2; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        check("reach_play", 7'(m_phase), 7'd2);
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 1, 1, 1);
        // reset code then ready, each exactly 4 ticks, presses ignored throughout
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            step(0, i[0], ~i[0]);
        end
        check("play_entry", 7'(m_phase), 7'd2);
        // left walks to the end and wins, then flashes with presses ignored
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
        for (int i = 0; i < 10; i++) step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        step(0, 0, 0, 1);
        // right walks to the end, simultaneous press at the end is a no-op, then right wins
        to_play();
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        // reset mid-play at 0000100, then the full sequence again
        step(0, 0, 0, 1);
        to_play();
        step(0, 0, 1);
        step(0, 0, 0, 1);
        to_play();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 299) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
